// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM read port among NUM_REQ renderers.
// Define SPRITE_ARB_PRIO0_EN to give requester 0 (background) strict priority.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 6,
  parameter int ROM_LAT = 1
) (
  input  logic                      vga_clk,
  input  logic                      Reset,
  input  logic                      frame_start,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_q,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] tag_q [ROM_LAT+1];
  logic [NUM_REQ-1:0] tag_d [ROM_LAT+1];

  logic [PTR_W-1:0]   start_s;
  logic [PTR_W-1:0]   cand_s;
  logic [PTR_W-1:0]   win_s;
  logic [NUM_REQ-1:0] rr_req_s;
  logic               found_s;
  logic               prio_hit_s;

  // Rotating search from the pointer; frame_start restarts the rotation at 0.
  always_comb begin
    start_s  = frame_start ? '0 : ptr_q;
    rr_req_s = req;
`ifdef SPRITE_ARB_PRIO0_EN
    rr_req_s[0] = 1'b0;
    prio_hit_s  = req[0];
`else
    prio_hit_s  = 1'b0;
`endif
    found_s = 1'b0;
    win_s   = '0;
    cand_s  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand_s = PTR_W'((int'(start_s) + off) % NUM_REQ);
      if (!found_s && rr_req_s[cand_s]) begin
        found_s = 1'b1;
        win_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end

    gnt_d  = '0;
    addr_d = addr_q;
    ptr_d  = start_s;
    if (prio_hit_s) begin
      gnt_d[0] = 1'b1;
      addr_d   = req_addr[0 +: ADDR_W];
    end else if (found_s) begin
      gnt_d[win_s] = 1'b1;
      addr_d       = req_addr[int'(win_s)*ADDR_W +: ADDR_W];
      ptr_d        = (win_s == PTR_W'(NUM_REQ-1)) ? '0 : win_s + PTR_W'(1);
    end else begin
      ptr_d = start_s;
    end
  end

  // Owner tags follow each grant through the ROM latency; rd_data captures rom_q one stage before rd_valid.
  always_comb begin
    tag_d[0] = gnt_q;
    for (int i = 1; i <= ROM_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    rd_data_d = (|tag_q[ROM_LAT-1]) ? rom_q : rd_data_q;
    busy_d    = |gnt_d;
    for (int i = 0; i <= ROM_LAT; i++) begin
      busy_d = busy_d | (|tag_d[i]);
    end
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      ptr_q     <= '0;
      gnt_q     <= '0;
      addr_q    <= '0;
      rd_data_q <= '0;
      busy_q    <= 1'b0;
      for (int i = 0; i <= ROM_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
      for (int i = 0; i <= ROM_LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign gnt         = gnt_q;
  assign rom_address = addr_q;
  assign rd_valid    = tag_q[ROM_LAT];
  assign rd_data     = rd_data_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a ROM model returning q = addr[DATA_W-1:0].
module tb_sprite_rom_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 11;
  localparam int DATA_W  = 6;
  localparam int ROM_LAT = 1;

  logic                      clk = 1'b0;
  logic                      Reset = 1'b1;
  logic                      frame_start = 1'b0;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]         rom_address;
  logic [DATA_W-1:0]         rom_q;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]         rd_data;
  logic                      busy;

  logic [ADDR_W-1:0] rom_pipe [ROM_LAT];

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] addr_tbl [4] = '{11'h123, 11'h2A5, 11'h3C7, 11'h0E9};
  logic [DATA_W-1:0] data_tbl [4] = '{6'h23, 6'h25, 6'h07, 6'h29};
`ifdef SPRITE_ARB_PRIO0_EN
  int exp_idx [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
  int exp_idx [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif

  sprite_rom_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)
  ) dut (
    .vga_clk(clk), .Reset(Reset), .frame_start(frame_start), .req(req),
    .req_addr(req_addr), .gnt(gnt), .rom_address(rom_address), .rom_q(rom_q),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_pipe[0] <= rom_address;
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_q = rom_pipe[ROM_LAT-1][DATA_W-1:0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NUM_REQ-1:0] oh;
    for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = addr_tbl[i];

    // reset state
    step(); step();
    Reset = 1'b0;
    check("rst_gnt", gnt, 0);
    check("rst_addr", rom_address, 0);
    check("rst_rdv", rd_valid, 0);
    check("rst_rdd", rd_data, 0);
    check("rst_busy", busy, 0);

    // single request, address 100 -> data 36 three cycles after sampling
    req_addr[0 +: ADDR_W] = 11'd100;
    req = 4'b0001;
    step();
    check("t1_gnt", gnt, 4'b0001);
    check("t1_addr", rom_address, 11'd100);
    req = 4'b0000;
    step();
    check("t1_rdv_early", rd_valid, 4'b0000);
    check("t1_busy", busy, 1);
    step();
    check("t1_rdv", rd_valid, 4'b0001);
    check("t1_rdd", rd_data, 6'd36);
    step();
    check("t1_rdv_off", rd_valid, 4'b0000);
    check("t1_rdd_hold", rd_data, 6'd36);
    check("t1_busy_off", busy, 0);
    req_addr[0 +: ADDR_W] = addr_tbl[0];

    // all requesting; frame_start restarts at 0
    req = 4'b1111;
    frame_start = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      frame_start = 1'b0;
      oh = 4'b0001 << exp_idx[c];
      check("rr_gnt", gnt, oh);
      check("rr_addr", rom_address, addr_tbl[exp_idx[c]]);
      if (c >= 2) begin
        oh = 4'b0001 << exp_idx[c-2];
        check("rr_rdv", rd_valid, oh);
        check("rr_rdd", rd_data, data_tbl[exp_idx[c-2]]);
      end else begin
        check("rr_busy", busy, 1);
      end
    end

    // idle drain
    req = 4'b0000;
    step();
    check("dr_gnt", gnt, 0);
    oh = 4'b0001 << exp_idx[6];
    check("dr_rdv6", rd_valid, oh);
    step();
    oh = 4'b0001 << exp_idx[7];
    check("dr_rdv7", rd_valid, oh);
    check("dr_busy_hi", busy, 1);
    step();
    check("dr_rdv_off", rd_valid, 0);
    check("dr_busy_lo", busy, 0);
    step(); step();
    check("dr_gnt_idle", gnt, 0);
    check("dr_addr_hold", rom_address, addr_tbl[exp_idx[7]]);
    check("dr_rdd_hold", rd_data, data_tbl[exp_idx[7]]);

    // wrap-around and frame_start override
    req = 4'b0010; step(); check("wr_g1", gnt, 4'b0010);
    req = 4'b0011; step(); check("wr_wrap0", gnt, 4'b0001);
    req = 4'b0010; step(); check("wr_then1", gnt, 4'b0010);
    req = 4'b0100; step(); check("wr_g2", gnt, 4'b0100);
    req = 4'b1001; frame_start = 1'b1; step(); check("fs_gnt0", gnt, 4'b0001);
    frame_start = 1'b0;
    req = 4'b1000; step(); check("fs_then3", gnt, 4'b1000);

    // lone requester held gets back-to-back grants
    req = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      step();
      check("solo_gnt", gnt, 4'b0001);
    end

    // reset mid-flight discards outstanding reads
    req = 4'b1111; step(); step();
    check("mf_busy", busy, 1);
    req = 4'b0000;
    Reset = 1'b1; frame_start = 1'b1;
    step();
    Reset = 1'b0; frame_start = 1'b0;
    check("mf_gnt", gnt, 0);
    check("mf_addr", rom_address, 0);
    check("mf_rdv", rd_valid, 0);
    check("mf_rdd", rd_data, 0);
    check("mf_busy0", busy, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("mf_no_rdv", rd_valid, 0);
      check("mf_no_busy", busy, 0);
    end

`ifdef SPRITE_ARB_PRIO0_EN
    // background priority
    req = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      step();
      check("p0_gnt", gnt, 4'b0001);
    end
    req = 4'b0110; frame_start = 1'b1;
    step(); frame_start = 1'b0; check("p0_a1", gnt, 4'b0010);
    step(); check("p0_a2", gnt, 4'b0100);
    step(); check("p0_a3", gnt, 4'b0010);
    step(); check("p0_a4", gnt, 4'b0100);
    req = 4'b0000;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
